// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, captures imem read data into a PC-tagged queue, hands {pc, instr} to decode.
// Optional misaligned-redirect fault handling is enabled by defining IFETCH_ALIGN_CHECK_EN.
module instruction_fetch #(
  parameter logic [63:0] RESET_PC   = 64'h0,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic [63:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [63:0] instr_pc,
  output logic        fetch_fault
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  logic [63:0]   pc;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [63:0]   fifo_pc    [FIFO_DEPTH];
  logic [31:0]   fifo_instr [FIFO_DEPTH];

  logic          fetch_en;
  logic          pop;
  logic          push;
  logic [63:0]   redirect_target;

`ifdef IFETCH_ALIGN_CHECK_EN
  typedef enum logic {RUN = 1'b0, FAULT = 1'b1} state_t;
  state_t state;
  state_t state_next;
  logic   misaligned;

  assign misaligned      = redirect_pc[1:0] != 2'b00;
  assign redirect_target = redirect_pc;

  always_ff @(posedge clk) begin
    if (rst) state <= RUN;
    else     state <= state_next;
  end

  // Only a redirect moves the FSM; its alignment picks the destination.
  always_comb begin
    state_next = state;
    if (redirect_valid) state_next = misaligned ? FAULT : RUN;
  end

  always_comb begin
    fetch_en    = (state == RUN);
    fetch_fault = (state == FAULT);
  end
`else
  logic unused_redirect_lo;

  assign unused_redirect_lo = ^redirect_pc[1:0];
  assign redirect_target    = {redirect_pc[63:2], 2'b00};
  assign fetch_en           = 1'b1;
  assign fetch_fault        = 1'b0;
`endif

  assign imem_addr   = pc;
  assign instr_valid = (count != '0);
  assign pop         = instr_valid & instr_ready;
  assign push        = fetch_en & ~redirect_valid & ((count < DEPTH_C) | pop);

  // Queue control: reset beats redirect, redirect beats any push/pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc     <= RESET_PC;
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else if (redirect_valid) begin
      pc     <= redirect_target;
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (push) begin
        pc     <= pc + 64'd4;
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  // Queue storage carries no reset; count gates everything read from it.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc[wr_ptr]    <= pc;
      fifo_instr[wr_ptr] <= imem_data;
    end
  end

  assign instr    = instr_valid ? fifo_instr[rd_ptr] : 32'h0;
  assign instr_pc = instr_valid ? fifo_pc[rd_ptr]    : 64'h0;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed scenarios with literal expectations plus randomized traffic
// checked every cycle against a queue-based reference model.
module tb_instruction_fetch;

  localparam logic [63:0] RPC   = 64'h1000;
  localparam int          DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] imem_addr;
  logic [31:0] imem_data;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [63:0] instr_pc;
  logic        fetch_fault;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] ins;
  } entry_t;

  entry_t      mq[$];
  logic [63:0] mpc;
  logic        mfault;

  instruction_fetch #(.RESET_PC(RPC), .FIFO_DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .fetch_fault    (fetch_fault)
  );

  always #5 clk = ~clk;

  // Memory contents: word at 0x1000+4i holds 0x100+i.
  function automatic logic [31:0] memf(input logic [63:0] a);
    return 32'(a >> 2) - 32'h300;
  endfunction

  assign imem_data = memf(imem_addr);

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_update();
    logic pop;
    logic push;
    if (rst) begin
      mq.delete();
      mpc    = RPC;
      mfault = 1'b0;
    end else if (redirect_valid) begin
      mq.delete();
`ifdef IFETCH_ALIGN_CHECK_EN
      mpc    = redirect_pc;
      mfault = (redirect_pc[1:0] != 2'b00);
`else
      mpc    = redirect_pc & ~64'h3;
`endif
    end else begin
      pop  = (mq.size() > 0) && instr_ready;
      push = !mfault && ((mq.size() < DEPTH) || pop);
      if (pop) void'(mq.pop_front());
      if (push) begin
        mq.push_back('{pc: mpc, ins: memf(mpc)});
        mpc = mpc + 64'd4;
      end
    end
  endtask

  task automatic compare_model();
    logic        v;
    v = (mq.size() != 0);
    chk("m_valid", 64'(instr_valid), 64'(v));
    chk("m_instr", 64'(instr), v ? 64'(mq[0].ins) : 64'h0);
    chk("m_instr_pc", instr_pc, v ? mq[0].pc : 64'h0);
    chk("m_imem_addr", imem_addr, mpc);
    chk("m_fault", 64'(fetch_fault), 64'(mfault));
  endtask

  task automatic step(input logic r, input logic rdy, input logic rv, input logic [63:0] rp);
    rst            = r;
    instr_ready    = rdy;
    redirect_valid = rv;
    redirect_pc    = rp;
    model_update();
    @(negedge clk);
    compare_model();
  endtask

  initial begin
    logic [63:0] rp;
    rst = 1'b1; instr_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    mpc = RPC; mfault = 1'b0;

    // Reset state
    step(1, 0, 0, 0);
    step(1, 1, 0, 0);
    chk("rst_valid", 64'(instr_valid), 0);
    chk("rst_instr", 64'(instr), 0);
    chk("rst_instr_pc", instr_pc, 0);
    chk("rst_addr", imem_addr, 64'h1000);
    chk("rst_fault", 64'(fetch_fault), 0);

    // Streaming with ready held high
    step(0, 1, 0, 0);
    chk("s1_pc0", instr_pc, 64'h1000);
    chk("s1_in0", 64'(instr), 64'h100);
    step(0, 1, 0, 0);
    chk("s1_pc1", instr_pc, 64'h1004);
    chk("s1_in1", 64'(instr), 64'h101);
    step(0, 1, 0, 0);
    chk("s1_pc2", instr_pc, 64'h1008);
    chk("s1_in2", 64'(instr), 64'h102);

    // Backpressure: queue fills, pc stalls, then resumes in order
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0);
    chk("s2_addr_hold", imem_addr, 64'h1010);
    chk("s2_head_hold", instr_pc, 64'h1008);
    step(0, 1, 0, 0);
    chk("s2_resume0", instr_pc, 64'h100C);
    step(0, 1, 0, 0);
    chk("s2_resume1", instr_pc, 64'h1010);

    // Redirect on a full queue
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 1, 1, 64'h2000);
    chk("s3_flush_valid", 64'(instr_valid), 0);
    chk("s3_addr", imem_addr, 64'h2000);
    step(0, 1, 0, 0);
    chk("s3_pc", instr_pc, 64'h2000);
    chk("s3_instr", 64'(instr), 64'h500);

    // PC wrap at the top of the address space
    step(0, 1, 1, 64'hFFFF_FFFF_FFFF_FFF8);
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    chk("s4_top", instr_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    step(0, 1, 0, 0);
    chk("s4_wrap_valid", 64'(instr_valid), 1);
    chk("s4_wrap_pc", instr_pc, 64'h0);

    // Misaligned redirect
    step(0, 1, 1, 64'h2002);
`ifdef IFETCH_ALIGN_CHECK_EN
    chk("s5_fault", 64'(fetch_fault), 1);
    chk("s5_addr", imem_addr, 64'h2002);
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    chk("s5_fault_held", 64'(fetch_fault), 1);
    chk("s5_valid_held", 64'(instr_valid), 0);
    step(0, 1, 1, 64'h3000);
    chk("s5_cleared", 64'(fetch_fault), 0);
    step(0, 1, 0, 0);
    chk("s5_pc", instr_pc, 64'h3000);
`else
    chk("s5_addr", imem_addr, 64'h2000);
    chk("s5_nofault", 64'(fetch_fault), 0);
    step(0, 1, 0, 0);
    chk("s5_pc", instr_pc, 64'h2000);
`endif

    // Reset mid-stream with a full queue
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(1, 1, 1, 64'h4000);
    chk("s6_valid", 64'(instr_valid), 0);
    chk("s6_addr", imem_addr, RPC);
    step(0, 1, 0, 0);
    chk("s6_pc", instr_pc, RPC);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      rp = {$urandom(), $urandom()};
      if ($urandom_range(0, 3) != 0) rp[1:0] = 2'b00;
      step($urandom_range(0, 99) == 0,
           $urandom_range(0, 9) < 7,
           $urandom_range(0, 15) == 0,
           rp);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
